// File: rtl/drive_ctrl_pkg.sv
// Shared types and helpers for the drive-mode controller.
// State encoding and hysteresis threshold arithmetic.
package drive_ctrl_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DRIVE  = 3'd2,
      S_MOTION = 3'd3,
      S_EMERG  = 3'd4,
      S_PARK   = 3'd5
   } state_t;

   function automatic int hyst_lo(input int thr, input int hyst);
      return thr - hyst;
   endfunction

endpackage

// File: rtl/obst_debounce.sv
// Obstacle sensor debouncer: the output follows the raw input only
// after OBST_DEB consecutive samples disagreeing with it.
module obst_debounce #(
   parameter int OBST_DEB = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic db
);

   localparam int CW = (OBST_DEB > 1) ? $clog2(OBST_DEB) : 1;
   localparam logic [CW-1:0] LAST = CW'(OBST_DEB - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
         db  <= 1'b0;
      end else if (raw == db) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
         db  <= raw;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/drive_ctrl_fsm.sv
// Vehicle drive-mode sequencer with registered accelerate/brake,
// speed hysteresis, park-settle timer and emergency event counter.
module drive_ctrl_fsm
   import drive_ctrl_pkg::*;
#(
   parameter int SPEED_W    = 8,
   parameter int DRIVE_SPD  = 10,
   parameter int MOTION_SPD = 30,
   parameter int MAX_SPD    = 40,
   parameter int HYST       = 2,
   parameter int OBST_DEB   = 3,
   parameter int PARK_HOLD  = 4,
   parameter int CNT_W      = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [SPEED_W-1:0] speed,
   input  logic               obstacle,
   input  logic               enable,
   input  logic               park_req,
   output logic               accelerate,
   output logic               brake,
   output logic [STATE_W-1:0] state_o,
   output logic               obst_db,
   output logic [CNT_W-1:0]   emerg_cnt
);

   localparam logic [SPEED_W-1:0] DRV_HI = SPEED_W'(DRIVE_SPD);
   localparam logic [SPEED_W-1:0] DRV_LO =
      SPEED_W'(hyst_lo(DRIVE_SPD, HYST));
   localparam logic [SPEED_W-1:0] MOT_HI = SPEED_W'(MOTION_SPD);
   localparam logic [SPEED_W-1:0] MOT_LO =
      SPEED_W'(hyst_lo(MOTION_SPD, HYST));
   localparam logic [SPEED_W-1:0] MAX_HI = SPEED_W'(MAX_SPD);

   localparam int PW = (PARK_HOLD > 1) ? $clog2(PARK_HOLD) : 1;
   localparam logic [PW-1:0] PARK_LAST = PW'(PARK_HOLD - 1);

   state_t        state, nxt;
   logic [PW-1:0] park_cnt, park_nxt;
   logic          acc_nxt, brk_nxt;
   logic          spd_zero, leave;
   logic          cnt_inc;

   obst_debounce #(
      .OBST_DEB(OBST_DEB)
   ) u_deb (
      .clk  (clk),
      .reset(reset),
      .raw  (obstacle),
      .db   (obst_db)
   );

   assign spd_zero = (speed == '0);
   assign leave    = !enable || park_req;

   always_comb begin
      nxt      = state;
      park_nxt = '0;
      case (state)
         S_IDLE: begin
            if (enable && !park_req && !obst_db && spd_zero)
               nxt = S_START;
         end
         S_START: begin
            if (obst_db)               nxt = S_EMERG;
            else if (leave)            nxt = S_PARK;
            else if (speed >= DRV_HI)  nxt = S_DRIVE;
         end
         S_DRIVE: begin
            if (obst_db)               nxt = S_EMERG;
            else if (leave)            nxt = S_PARK;
            else if (speed >= MOT_HI)  nxt = S_MOTION;
            else if (speed < DRV_LO)   nxt = S_START;
         end
         S_MOTION: begin
            if (obst_db)               nxt = S_EMERG;
            else if (leave)            nxt = S_PARK;
            else if (speed < MOT_LO)   nxt = S_DRIVE;
         end
         S_EMERG: begin
            if (!obst_db && spd_zero)  nxt = S_IDLE;
         end
         S_PARK: begin
            if (obst_db)                   nxt = S_EMERG;
            else if (!spd_zero)            park_nxt = '0;
            else if (park_cnt == PARK_LAST) nxt = S_IDLE;
            else                           park_nxt = park_cnt + 1'b1;
         end
         default: nxt = S_IDLE;
      endcase
   end

   // Commands follow the state being entered, not the one being left.
   always_comb begin
      acc_nxt = 1'b0;
      brk_nxt = 1'b0;
      case (nxt)
         S_IDLE:   brk_nxt = !spd_zero;
         S_START:  acc_nxt = 1'b1;
         S_DRIVE:  acc_nxt = (speed < MOT_HI);
         S_MOTION: brk_nxt = (speed > MAX_HI);
         S_EMERG:  brk_nxt = 1'b1;
         S_PARK:   brk_nxt = !spd_zero;
         default: begin
            acc_nxt = 1'b0;
            brk_nxt = 1'b0;
         end
      endcase
   end

   assign cnt_inc = (nxt == S_EMERG) && (state != S_EMERG);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         park_cnt   <= '0;
         accelerate <= 1'b0;
         brake      <= 1'b0;
         emerg_cnt  <= '0;
      end else begin
         state      <= nxt;
         park_cnt   <= park_nxt;
         accelerate <= acc_nxt;
         brake      <= brk_nxt;
         if (cnt_inc && (emerg_cnt != '1))
            emerg_cnt <= emerg_cnt + 1'b1;
      end
   end

   assign state_o = state;

endmodule
